// File: rtl/reg_status_file_pkg.sv
// Shared CPU definitions: widths, tag/index types, opcodes.
// Imported by the register status file and its read ports.
package cpu_defs;

  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ROB_IDX_W  = 5;
  localparam int ROB_SIZE   = 2 ** ROB_IDX_W;

  typedef logic [ROB_IDX_W-1:0]  rob_tag_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

endpackage

// File: rtl/reg_status_file_if.sv
// Issue/commit/read bundle between pipeline and register status file.
// master = pipeline side, slave = register file side.
interface reg_status_file_if;
  import cpu_defs::*;

  logic     rdy_in;
  logic     flush_in;
  logic     issue_valid_in;
  reg_idx_t issue_rd_in;
  rob_tag_t issue_tag_in;
  logic     commit_valid_in;
  reg_idx_t commit_rd_in;
  rob_tag_t commit_tag_in;
  word_t    commit_value_in;
  reg_idx_t rs1_in;
  reg_idx_t rs2_in;
  word_t    rs1_value_out;
  logic     rs1_busy_out;
  rob_tag_t rs1_tag_out;
  word_t    rs2_value_out;
  logic     rs2_busy_out;
  rob_tag_t rs2_tag_out;

  modport master (
    output rdy_in, flush_in,
    output issue_valid_in, issue_rd_in, issue_tag_in,
    output commit_valid_in, commit_rd_in,
    output commit_tag_in, commit_value_in,
    output rs1_in, rs2_in,
    input  rs1_value_out, rs1_busy_out, rs1_tag_out,
    input  rs2_value_out, rs2_busy_out, rs2_tag_out
  );

  modport slave (
    input  rdy_in, flush_in,
    input  issue_valid_in, issue_rd_in, issue_tag_in,
    input  commit_valid_in, commit_rd_in,
    input  commit_tag_in, commit_value_in,
    input  rs1_in, rs2_in,
    output rs1_value_out, rs1_busy_out, rs1_tag_out,
    output rs2_value_out, rs2_busy_out, rs2_tag_out
  );

endinterface

// File: rtl/reg_status_file_read_port.sv
// One source read port: storage lookup with commit bypass.
// A matching commit makes the operand ready in the same cycle.
module reg_read_port
  import cpu_defs::*;
(
  input  reg_idx_t                        rs,
  input  logic [REG_COUNT-1:0][XLEN-1:0]  values,
  input  logic [REG_COUNT-1:0]            busy,
  input  rob_tag_t [REG_COUNT-1:0]        tags,
  input  logic                            commit_valid,
  input  reg_idx_t                        commit_rd,
  input  rob_tag_t                        commit_tag,
  input  word_t                           commit_value,
  output word_t                           value,
  output logic                            busy_out,
  output rob_tag_t                        tag
);

  logic hit;

  // Forward the committing value when it resolves this producer
  always_comb begin
    hit = commit_valid
        && (commit_rd == rs)
        && (rs != '0)
        && busy[rs]
        && (tags[rs] == commit_tag);
    tag      = tags[rs];
    busy_out = hit ? 1'b0 : busy[rs];
    value    = hit ? commit_value : values[rs];
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy bit and ROB tag.
// Commit writes values; issue renames; flush clears all busy bits.
module reg_status_file
  import cpu_defs::*;
(
  input logic               clk_in,
  input logic               rst_in,
  reg_status_file_if.slave  bus
);

  logic [REG_COUNT-1:0][XLEN-1:0] value_q;
  logic [REG_COUNT-1:0]           busy_q;
  rob_tag_t [REG_COUNT-1:0]       tag_q;

  // Per-entry update; x0 stays at its reset state forever
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else if (bus.rdy_in) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (bus.commit_valid_in &&
            bus.commit_rd_in == reg_idx_t'(i))
          value_q[i] <= bus.commit_value_in;
        if (bus.flush_in) begin
          busy_q[i] <= 1'b0;
        end else if (bus.issue_valid_in &&
                     bus.issue_rd_in == reg_idx_t'(i)) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= bus.issue_tag_in;
        end else if (bus.commit_valid_in &&
                     bus.commit_rd_in == reg_idx_t'(i) &&
                     busy_q[i] &&
                     tag_q[i] == bus.commit_tag_in) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  reg_read_port u_rs1 (
    .rs           (bus.rs1_in),
    .values       (value_q),
    .busy         (busy_q),
    .tags         (tag_q),
    .commit_valid (bus.commit_valid_in),
    .commit_rd    (bus.commit_rd_in),
    .commit_tag   (bus.commit_tag_in),
    .commit_value (bus.commit_value_in),
    .value        (bus.rs1_value_out),
    .busy_out     (bus.rs1_busy_out),
    .tag          (bus.rs1_tag_out)
  );

  reg_read_port u_rs2 (
    .rs           (bus.rs2_in),
    .values       (value_q),
    .busy         (busy_q),
    .tags         (tag_q),
    .commit_valid (bus.commit_valid_in),
    .commit_rd    (bus.commit_rd_in),
    .commit_tag   (bus.commit_tag_in),
    .commit_value (bus.commit_value_in),
    .value        (bus.rs2_value_out),
    .busy_out     (bus.rs2_busy_out),
    .tag          (bus.rs2_tag_out)
  );

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: scripted vector table plus
// hand sequences for stall and asynchronous reset.
module tb_reg_status_file;
  import cpu_defs::*;

  typedef struct {
    logic        rdy;
    logic        fl;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  itag;
    logic        cv;
    logic [4:0]  crd;
    logic [4:0]  ctag;
    logic [31:0] cval;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1v;
    logic        e1b;
    logic [4:0]  e1t;
    logic [31:0] e2v;
    logic        e2b;
    logic [4:0]  e2t;
  } vec_t;

  localparam int NV = 24;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total  = 0;
  int   bad    = 0;
  vec_t tbl [NV];

  reg_status_file_if bus ();

  reg_status_file dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(
    input logic        fl,
    input logic        iv,
    input logic [4:0]  ird,
    input logic [4:0]  itag,
    input logic        cv,
    input logic [4:0]  crd,
    input logic [4:0]  ctag,
    input logic [31:0] cval,
    input logic [4:0]  rs1,
    input logic [31:0] e1v,
    input logic        e1b,
    input logic [4:0]  e1t,
    input logic [4:0]  rs2,
    input logic [31:0] e2v,
    input logic        e2b,
    input logic [4:0]  e2t
  );
    vec_t v;
    v.rdy = 1'b1; v.fl = fl;
    v.iv = iv; v.ird = ird; v.itag = itag;
    v.cv = cv; v.crd = crd; v.ctag = ctag; v.cval = cval;
    v.rs1 = rs1; v.e1v = e1v; v.e1b = e1b; v.e1t = e1t;
    v.rs2 = rs2; v.e2v = e2v; v.e2b = e2b; v.e2t = e2t;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rdy_in          = v.rdy;
    bus.flush_in        = v.fl;
    bus.issue_valid_in  = v.iv;
    bus.issue_rd_in     = v.ird;
    bus.issue_tag_in    = v.itag;
    bus.commit_valid_in = v.cv;
    bus.commit_rd_in    = v.crd;
    bus.commit_tag_in   = v.ctag;
    bus.commit_value_in = v.cval;
    bus.rs1_in          = v.rs1;
    bus.rs2_in          = v.rs2;
  endtask

  task automatic check_reads(input string nm, input vec_t v);
    chk({nm, " rs1 val"}, bus.rs1_value_out, v.e1v);
    chk({nm, " rs1 busy"}, 32'(bus.rs1_busy_out), 32'(v.e1b));
    chk({nm, " rs1 tag"}, 32'(bus.rs1_tag_out), 32'(v.e1t));
    chk({nm, " rs2 val"}, bus.rs2_value_out, v.e2v);
    chk({nm, " rs2 busy"}, 32'(bus.rs2_busy_out), 32'(v.e2b));
    chk({nm, " rs2 tag"}, 32'(bus.rs2_tag_out), 32'(v.e2t));
  endtask

  initial begin
    vec_t h;
    // fl iv ird itag cv crd ctag cval | rs1 v b t | rs2 v b t
    tbl[0]  = mk(0,0,0,0,  0,0,0,0,       5,0,0,0,        0,0,0,0);
    tbl[1]  = mk(0,1,0,3,  0,0,0,0,       0,0,0,0,        5,0,0,0);
    tbl[2]  = mk(0,0,0,0,  0,0,0,0,       0,0,0,0,        5,0,0,0);
    tbl[3]  = mk(0,1,5,7,  0,0,0,0,       5,0,0,0,        0,0,0,0);
    tbl[4]  = mk(0,0,0,0,  0,0,0,0,       5,0,1,7,        0,0,0,0);
    tbl[5]  = mk(0,0,0,0,  1,5,7,'hDEAD,  5,'hDEAD,0,7,   5,'hDEAD,0,7);
    tbl[6]  = mk(0,0,0,0,  0,0,0,0,       5,'hDEAD,0,7,   0,0,0,0);
    tbl[7]  = mk(0,1,5,7,  0,0,0,0,       5,'hDEAD,0,7,   0,0,0,0);
    tbl[8]  = mk(0,1,5,9,  0,0,0,0,       5,'hDEAD,1,7,   0,0,0,0);
    tbl[9]  = mk(0,0,0,0,  1,5,7,1,       5,'hDEAD,1,9,   0,0,0,0);
    tbl[10] = mk(0,0,0,0,  0,0,0,0,       5,1,1,9,        0,0,0,0);
    tbl[11] = mk(0,0,0,0,  1,5,9,2,       5,2,0,9,        0,0,0,0);
    tbl[12] = mk(0,0,0,0,  0,0,0,0,       5,2,0,9,        0,0,0,0);
    tbl[13] = mk(0,1,5,4,  0,0,0,0,       5,2,0,9,        0,0,0,0);
    tbl[14] = mk(0,1,5,12, 1,5,4,'h11,    5,'h11,0,4,     0,0,0,0);
    tbl[15] = mk(0,0,0,0,  0,0,0,0,       5,'h11,1,12,    0,0,0,0);
    tbl[16] = mk(0,1,3,1,  0,0,0,0,       3,0,0,0,        8,0,0,0);
    tbl[17] = mk(0,1,8,2,  0,0,0,0,       3,0,1,1,        8,0,0,0);
    tbl[18] = mk(1,1,9,5,  1,3,20,'h55,   3,0,1,1,        8,0,1,2);
    tbl[19] = mk(0,0,0,0,  0,0,0,0,       3,'h55,0,1,     8,0,0,2);
    tbl[20] = mk(0,0,0,0,  0,0,0,0,       9,0,0,0,        5,'h11,0,12);
    tbl[21] = mk(0,0,0,0,  1,0,0,'hFF,    0,0,0,0,        0,0,0,0);
    tbl[22] = mk(0,0,0,0,  0,0,0,0,       0,0,0,0,        3,'h55,0,1);
    tbl[23] = mk(0,1,5,6,  0,0,0,0,       5,'h11,0,12,    0,0,0,0);

    drive(mk(0,0,0,0, 0,0,0,0, 5,0,0,0, 0,0,0,0));
    #1;
    chk("reset rs1 val", bus.rs1_value_out, 32'h0);
    chk("reset rs1 busy", 32'(bus.rs1_busy_out), 32'h0);
    chk("reset rs1 tag", 32'(bus.rs1_tag_out), 32'h0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk_in);
      drive(tbl[k]);
      #1;
      check_reads($sformatf("vec%0d", k), tbl[k]);
    end

    // stall: everything asserted with rdy low must be ignored
    @(negedge clk_in);
    h = mk(1,1,5,10, 1,7,0,'h77, 5,0,0,0, 7,0,0,0);
    h.rdy = 1'b0;
    drive(h);
    @(negedge clk_in);
    drive(mk(0,0,0,0, 0,0,0,0, 5,0,0,0, 7,0,0,0));
    #1;
    chk("stall x5 val", bus.rs1_value_out, 32'h11);
    chk("stall x5 busy", 32'(bus.rs1_busy_out), 32'h1);
    chk("stall x5 tag", 32'(bus.rs1_tag_out), 32'h6);
    chk("stall x7 val", bus.rs2_value_out, 32'h0);

    // asynchronous reset between edges
    @(negedge clk_in);
    drive(mk(0,0,0,0, 0,0,0,0, 5,0,0,0, 3,0,0,0));
    #1;
    chk("pre-rst x3 val", bus.rs2_value_out, 32'h55);
    #1;
    rst_in = 1'b1;
    #1;
    chk("rst x5 val", bus.rs1_value_out, 32'h0);
    chk("rst x5 busy", 32'(bus.rs1_busy_out), 32'h0);
    chk("rst x5 tag", 32'(bus.rs1_tag_out), 32'h0);
    chk("rst x3 val", bus.rs2_value_out, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("post-rst x3 val", bus.rs2_value_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
